timer_delay_master: RTL and testbench

//  Initiator side of the timer command interface (cs/op/addr/data_in -> rdy).

---
 rtl/timer_delay_master.sv | 156 +++++++++++++++
 tb/tb_timer_delay_master.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_delay_master.sv
`default_nettype none
// ============================================================================
// timer_delay_master : splits a 48-bit delay into timer loads, pulses done
// Revision 1.0
// ============================================================================
module timer_delay_master #(
  parameter int ARM_WAIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [47:0] req_delay,
  input  logic        abort,
  output logic        busy,
  output logic        done,
  output logic        tmr_cs,
  output logic [3:0]  tmr_op,
  output logic [7:0]  tmr_addr,
  output logic [15:0] tmr_data,
  input  logic        tmr_rdy
);

  localparam int CNT_W = $clog2(ARM_WAIT + 1);
  localparam logic [CNT_W-1:0] C_ARM_LAST = CNT_W'(ARM_WAIT - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_ARM  = 3'd2,
    S_WAIT = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [47:0]       delay_q, delay_d;
  logic              seg_q, seg_d;
  logic [CNT_W-1:0]  arm_cnt_q, arm_cnt_d;
  logic              cs_q, cs_d;
  logic              done_q, done_d;
  logic [3:0]        op_q, op_d;
  logic [7:0]        addr_q, addr_d;
  logic [15:0]       data_q, data_d;
  logic              seg_complete;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      delay_q   <= '0;
      seg_q     <= 1'b0;
      arm_cnt_q <= '0;
      cs_q      <= 1'b0;
      done_q    <= 1'b0;
      op_q      <= '0;
      addr_q    <= '0;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      delay_q   <= delay_d;
      seg_q     <= seg_d;
      arm_cnt_q <= arm_cnt_d;
      cs_q      <= cs_d;
      done_q    <= done_d;
      op_q      <= op_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    delay_d      = delay_q;
    seg_d        = seg_q;
    arm_cnt_d    = arm_cnt_q;
    seg_complete = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          delay_d = req_delay;
          if (req_delay[47:24] != 24'd0) begin
            state_d = S_LOAD;
            seg_d   = 1'b1;
          end else if (req_delay[23:0] != 24'd0) begin
            state_d = S_LOAD;
            seg_d   = 1'b0;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_LOAD: begin
        state_d   = S_ARM;
        arm_cnt_d = '0;
      end
      S_ARM: begin
        // A timer that never drops rdy (e.g. tiny count) is treated as expired.
        if (!tmr_rdy) begin
          state_d = S_WAIT;
        end else if (arm_cnt_q == C_ARM_LAST) begin
          seg_complete = 1'b1;
        end else begin
          arm_cnt_d = arm_cnt_q + CNT_W'(1);
        end
      end
      S_WAIT: begin
        if (tmr_rdy) begin
          seg_complete = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (seg_complete) begin
      if (seg_q && (delay_q[23:0] != 24'd0)) begin
        state_d = S_LOAD;
        seg_d   = 1'b0;
      end else begin
        state_d = S_DONE;
      end
    end

    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
    end
  end

  // Strobe and command fields are registered so they align with the LOAD cycle.
  always_comb begin
    cs_d   = (state_d == S_LOAD);
    done_d = (state_d == S_DONE);
    op_d   = op_q;
    addr_d = addr_q;
    data_d = data_q;
    if (state_d == S_LOAD) begin
      op_d   = {3'b000, seg_d};
      addr_d = seg_d ? delay_d[47:40] : delay_d[23:16];
      data_d = seg_d ? delay_d[39:24] : delay_d[15:0];
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign tmr_cs    = cs_q;
  assign tmr_op    = op_q;
  assign tmr_addr  = addr_q;
  assign tmr_data  = data_q;

endmodule
`default_nettype wire

// File: tb/tb_timer_delay_master.sv
`default_nettype none
// ============================================================================
// tb_timer_delay_master : scoreboard bench with a behavioural timer model
// Revision 1.0
// ============================================================================
module tb_timer_delay_master;

  // High-segment loads are scaled down so the bench stays short.
  localparam int SCALE = 16;

  typedef struct {
    logic [3:0]  op;
    logic [7:0]  addr;
    logic [15:0] data;
  } cmd_t;

  typedef struct {
    int lo;
    int hi;
  } lat_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [47:0] req_delay = '0;
  logic        abort = 1'b0;
  logic        busy;
  logic        done;
  logic        tmr_cs;
  logic [3:0]  tmr_op;
  logic [7:0]  tmr_addr;
  logic [15:0] tmr_data;
  logic        tmr_rdy = 1'b1;

  logic [47:0] mcnt = '0;
  logic        marm = 1'b0;
  logic        stuck = 1'b0;

  cmd_t exp_cs[$];
  lat_t exp_done[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   t_xfer = 0;

  timer_delay_master #(.ARM_WAIT(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_delay (req_delay),
    .abort     (abort),
    .busy      (busy),
    .done      (done),
    .tmr_cs    (tmr_cs),
    .tmr_op    (tmr_op),
    .tmr_addr  (tmr_addr),
    .tmr_data  (tmr_data),
    .tmr_rdy   (tmr_rdy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Timer: rdy falls two edges after cs, rises once the loaded count has run out.
  always @(posedge clk) begin
    if (tmr_cs) begin
      mcnt <= tmr_op[0] ? 48'({24'b0, tmr_addr, tmr_data}) * 48'(SCALE)
                        : 48'({24'b0, tmr_addr, tmr_data});
      marm <= !stuck;
    end else if (marm) begin
      marm    <= 1'b0;
      tmr_rdy <= 1'b0;
    end else if (!tmr_rdy) begin
      if (mcnt <= 48'd1) tmr_rdy <= 1'b1;
      mcnt <= mcnt - 48'd1;
    end
  end

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event occurred with no expectation or bound expired", name);
  endtask

  task automatic push_cs(input logic [3:0] op, input logic [7:0] addr, input logic [15:0] data);
    cmd_t c;
    c.op = op; c.addr = addr; c.data = data;
    exp_cs.push_back(c);
  endtask

  task automatic push_done(input int lo, input int hi);
    lat_t l;
    l.lo = lo; l.hi = hi;
    exp_done.push_back(l);
  endtask

  // Monitor: pops and compares whenever the DUT presents a strobe or done.
  always @(negedge clk) begin
    cmd_t c;
    lat_t l;
    int   lat;
    if (req_valid && req_ready) t_xfer = cyc;
    if (tmr_cs) begin
      if (exp_cs.size() == 0) begin
        fail("unexpected_cs");
      end else begin
        c = exp_cs.pop_front();
        check("cs_op",   48'(tmr_op),   48'(c.op));
        check("cs_addr", 48'(tmr_addr), 48'(c.addr));
        check("cs_data", 48'(tmr_data), 48'(c.data));
      end
    end
    if (done) begin
      if (exp_done.size() == 0) begin
        fail("unexpected_done");
      end else begin
        l = exp_done.pop_front();
        lat = cyc - t_xfer;
        checks++;
        if (lat < l.lo || lat > l.hi) begin
          errors++;
          $display("FAIL done_latency: got %0d expected %0d..%0d", lat, l.lo, l.hi);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [47:0] d);
    int n = 0;
    req_valid = 1'b1;
    req_delay = d;
    while (!req_ready && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) fail("send_timeout");
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    while (busy && n < bound) begin
      tick();
      n++;
    end
    if (n >= bound) fail("idle_timeout");
    tick();
  endtask

  task automatic wait_rdy(input logic lvl, input int bound);
    int n = 0;
    while (tmr_rdy !== lvl && n < bound) begin
      tick();
      n++;
    end
    if (n >= bound) fail("rdy_timeout");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    // T1 reset
    repeat (3) tick();
    check("rst_ready", 48'(req_ready), 48'd1);
    check("rst_busy",  48'(busy),      48'd0);
    check("rst_done",  48'(done),      48'd0);
    check("rst_cs",    48'(tmr_cs),    48'd0);
    check("rst_op",    48'(tmr_op),    48'd0);
    check("rst_addr",  48'(tmr_addr),  48'd0);
    check("rst_data",  48'(tmr_data),  48'd0);
    rst = 1'b0;
    tick();

    // T2 low segment only
    push_cs(4'h0, 8'h00, 16'h03E8);
    push_done(1000, 1010);
    send(48'd1000);
    check("busy_ready", 48'(req_ready), 48'd0);
    check("busy_busy",  48'(busy),      48'd1);
    wait_idle(2000);

    // T3 high segment only
    push_cs(4'h1, 8'h00, 16'h0002);
    push_done(32, 42);
    send(48'h000002_000000);
    wait_idle(200);

    // T4 high then low segment
    push_cs(4'h1, 8'h00, 16'h0001);
    push_cs(4'h0, 8'h00, 16'h0010);
    push_done(32, 48);
    send(48'h000001_000010);
    wait_idle(200);

    // T5 zero delay back-to-back; abort in IDLE is ignored
    push_done(1, 1);
    push_done(1, 1);
    req_valid = 1'b1;
    req_delay = 48'd0;
    abort     = 1'b1;
    tick();
    abort = 1'b0;
    check("zero_ready_in_done", 48'(req_ready), 48'd0);
    tick();
    check("zero_ready_again", 48'(req_ready), 48'd1);
    tick();
    req_valid = 1'b0;
    repeat (3) tick();

    // rdy never drops: segment completes on the arm timeout
    stuck = 1'b1;
    push_cs(4'h0, 8'h00, 16'h0005);
    push_done(4, 8);
    send(48'd5);
    wait_idle(100);
    stuck = 1'b0;

    // T6a abort in WAIT of the high segment
    push_cs(4'h1, 8'h00, 16'h0001);
    send(48'h000001_000010);
    wait_rdy(1'b0, 50);
    tick();
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy",  48'(busy),      48'd0);
    check("abort_ready", 48'(req_ready), 48'd1);
    check("abort_done",  48'(done),      48'd0);
    repeat (40) tick();
    wait_rdy(1'b1, 100);

    // T6b reset in WAIT of the high segment
    push_cs(4'h1, 8'h00, 16'h0001);
    send(48'h000001_000010);
    wait_rdy(1'b0, 50);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_busy", 48'(busy),     48'd0);
    check("midrst_cs",   48'(tmr_cs),   48'd0);
    check("midrst_op",   48'(tmr_op),   48'd0);
    check("midrst_data", 48'(tmr_data), 48'd0);
    repeat (40) tick();
    wait_rdy(1'b1, 100);

    // New request after abort/reset
    push_cs(4'h0, 8'h00, 16'h0014);
    push_done(20, 30);
    send(48'd20);
    wait_idle(200);
    repeat (3) tick();

    check("cs_queue_empty",   48'(exp_cs.size()),   48'd0);
    check("done_queue_empty", 48'(exp_done.size()), 48'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
